// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake, iterative MUL/DIVU.
// Define ALU_SEQ_OVERFLOW_EN to add the registered ovf output.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
`ifdef ALU_SEQ_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             zero
);
  localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_AND = 4'b0000, OP_OR = 4'b0001,
                         OP_NOR = 4'b1100, OP_SLT = 4'b0111, OP_MUL = 4'b1000, OP_DIVU = 4'b1001;
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] op;
  logic [WIDTH-1:0] b, hi, lo, sum, dif, s_res, s_hi, mul_hi, mul_lo, div_hi, div_lo, it_hi, it_lo, div_d;
  logic [WIDTH:0] mul_sum, div_t;
  logic [CNT_W-1:0] cnt;
  logic accept, is_iter, last, div_ge;
  assign accept  = in_valid && in_ready;
  assign is_iter = alu_op == OP_MUL || (alu_op == OP_DIVU && op_b != '0);
  assign last    = cnt == CNT_W'(WIDTH - 1);
  assign sum     = op_a + op_b;
  assign dif     = op_a - op_b;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // Single-cycle ops; DIVU only lands here when the divisor is zero.
  always_comb begin
    s_res = alu_op == OP_ADD  ? sum :
            alu_op == OP_SUB  ? dif :
            alu_op == OP_AND  ? op_a & op_b :
            alu_op == OP_OR   ? op_a | op_b :
            alu_op == OP_NOR  ? ~(op_a | op_b) :
            alu_op == OP_SLT  ? WIDTH'($signed(op_a) < $signed(op_b)) :
            alu_op == OP_DIVU ? '1 : '0;
    s_hi  = alu_op == OP_DIVU ? op_a : '0;
  end
  // hi:lo is the shift-add product register for MUL and the remainder:quotient pair for DIVU.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo[M:1]};
    div_t   = {hi, lo[M]};
    div_ge  = div_t >= {1'b0, b};
    div_d   = div_t[M:0] - b;
    div_hi  = div_ge ? div_d : div_t[M:0];
    div_lo  = {lo[M-1:0], div_ge};
    it_hi   = op == OP_MUL ? mul_hi : div_hi;
    it_lo   = op == OP_MUL ? mul_lo : div_lo;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (is_iter ? BUSY : DONE) : IDLE;
      BUSY:    state_nx = last ? DONE : BUSY;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      b         <= '0;
      hi        <= '0;
      lo        <= '0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        op  <= alu_op;
        b   <= op_b;
        hi  <= '0;
        lo  <= op_a;
        cnt <= '0;
        if (!is_iter) begin
          result    <= s_res;
          result_hi <= s_hi;
          zero      <= s_res == '0;
`ifdef ALU_SEQ_OVERFLOW_EN
          ovf       <= alu_op == OP_ADD ? (op_a[M] == op_b[M] && sum[M] != op_a[M]) :
                       alu_op == OP_SUB ? (op_a[M] != op_b[M] && dif[M] != op_a[M]) : 1'b0;
`endif
        end
      end
      if (state == BUSY) begin
        hi  <= it_hi;
        lo  <= it_lo;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          result    <= it_lo;
          result_hi <= it_hi;
          zero      <= it_lo == '0;
`ifdef ALU_SEQ_OVERFLOW_EN
          ovf       <= op == OP_MUL && it_hi != '0;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq.
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, zero;
  logic [3:0] alu_op = 4'b0010;
  logic [31:0] op_a = '0, op_b = '0, result, result_hi;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic ovf;
`endif
  int n_chk = 0, n_err = 0, lat;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
`ifdef ALU_SEQ_OVERFLOW_EN
    .ovf(ovf),
`endif
    .zero(zero)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Present one op, scramble inputs after accept, and measure cycles until out_valid.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] bb);
    alu_op = o; op_a = a; op_b = bb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; alu_op = 4'b0000;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask
  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handoff_out_valid", 64'(out_valid), 64'd0);
    check("handoff_in_ready", 64'(in_ready), 64'd1);
  endtask
  initial begin
    in_valid = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_hi", 64'(result_hi), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
    check("add_lat", 64'(lat), 64'd1);
    check("add_res", 64'(result), 64'h8000_0000);
    check("add_zero", 64'(zero), 64'd0);
`ifdef ALU_SEQ_OVERFLOW_EN
    check("add_ovf", 64'(ovf), 64'd1);
`endif
    handoff();
    issue(4'b0110, 32'd5, 32'd5);
    check("sub_res", 64'(result), 64'd0);
    check("sub_zero", 64'(zero), 64'd1);
    handoff();
    issue(4'b0000, 32'hF0, 32'h0F);
    check("and_zero", 64'(zero), 64'd1);
    handoff();
    issue(4'b0001, 32'd0, 32'd3);
    check("or_res", 64'(result), 64'd3);
    check("or_zero", 64'(zero), 64'd0);
    handoff();
    issue(4'b1100, 32'd0, 32'h0000_FFFF);
    check("nor_res", 64'(result), 64'hFFFF_0000);
    handoff();
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    check("slt_true", 64'(result), 64'd1);
    handoff();
    issue(4'b0111, 32'd1, 32'hFFFF_FFFF);
    check("slt_false", 64'(result), 64'd0);
    check("slt_zero", 64'(zero), 64'd1);
    handoff();
    issue(4'b0110, 32'h8000_0000, 32'd1);
    check("sub_wrap", 64'(result), 64'h7FFF_FFFF);
`ifdef ALU_SEQ_OVERFLOW_EN
    check("sub_ovf", 64'(ovf), 64'd1);
`endif
    handoff();
    issue(4'b1000, 32'hFFFF_FFFF, 32'd2);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_lo", 64'(result), 64'hFFFF_FFFE);
    check("mul_hi", 64'(result_hi), 64'd1);
`ifdef ALU_SEQ_OVERFLOW_EN
    check("mul_ovf", 64'(ovf), 64'd1);
`endif
    handoff();
    issue(4'b1000, 32'd12345, 32'd6789);
    check("mul_small", {result_hi, result}, 64'd83810205);
    handoff();
    issue(4'b1001, 32'd100, 32'd7);
    check("divu_lat", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      check("divu_hold_q", 64'(result), 64'd14);
      check("divu_hold_r", 64'(result_hi), 64'd2);
      check("divu_hold_in_ready", 64'(in_ready), 64'd0);
      check("divu_hold_valid", 64'(out_valid), 64'd1);
      tick();
    end
    handoff();
    issue(4'b1001, 32'hFFFF_FFFF, 32'h0001_0000);
    check("divu_big", {result_hi, result}, {32'h0000_FFFF, 32'h0000_FFFF});
    handoff();
    issue(4'b1001, 32'd9, 32'd0);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_q", 64'(result), 64'hFFFF_FFFF);
    check("div0_r", 64'(result_hi), 64'd9);
    handoff();
    issue(4'b1111, 32'd5, 32'd6);
    check("undef_lat", 64'(lat), 64'd1);
    check("undef_res", {result_hi, result}, 64'd0);
    check("undef_zero", 64'(zero), 64'd1);
    handoff();
    alu_op = 4'b1000; op_a = 32'd7; op_b = 32'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("busy_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) lat++;
    end
    check("abort_no_valid", 64'(lat), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_result", 64'(result), 64'd0);
    issue(4'b0010, 32'd2, 32'd3);
    check("post_rst_add", 64'(result), 64'd5);
    handoff();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
